// File: rtl/icache_direct_mapped_if.sv
// rtl/icache_direct_mapped_if.sv - fetch-side and memory-side bus bundle for the instruction cache
interface icache_direct_mapped_if;
    logic         cpu_read;
    logic [31:0]  cpu_address;
    logic         flush;
    logic [31:0]  cpu_instruction;
    logic         cpu_busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    // Cache side
    modport slave (
        input  cpu_read, cpu_address, flush, mem_readdata, mem_busywait,
        output cpu_instruction, cpu_busywait, mem_read, mem_address
    );

    // Fetch stage / memory side
    modport master (
        output cpu_read, cpu_address, flush, mem_readdata, mem_busywait,
        input  cpu_instruction, cpu_busywait, mem_read, mem_address
    );
endinterface

// File: rtl/icache_direct_mapped.sv
// rtl/icache_direct_mapped.sv - direct-mapped read-only instruction cache with 4-word block refill
module icache_direct_mapped #(
    parameter int INDEX_BITS = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    icache_direct_mapped_if.slave bus
);
    localparam int TAG_BITS = 32 - 4 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit;
    logic                  unused_addr_bits;

    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [127:0]          data_q [LINES];

    state_t                state_q;
    logic                  flush_pending_q;
    logic                  mem_read_q;
    logic [27:0]           mem_address_q;
    logic [127:0]          block_q;

    // The fill target is taken from the latched block address, never the live bus
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;

    assign offset           = bus.cpu_address[3:2];
    assign index            = bus.cpu_address[4+INDEX_BITS-1:4];
    assign tag              = bus.cpu_address[31:4+INDEX_BITS];
    assign unused_addr_bits = ^bus.cpu_address[1:0];

    assign fill_index = mem_address_q[INDEX_BITS-1:0];
    assign fill_tag   = mem_address_q[27:INDEX_BITS];

    assign hit = valid_q[index] && (tag_q[index] == tag);

    assign bus.cpu_instruction = hit ? data_q[index][{offset, 5'b0} +: 32] : 32'h0;
    assign bus.cpu_busywait    = bus.cpu_read && !((state_q == IDLE) && hit);
    assign bus.mem_read        = mem_read_q;
    assign bus.mem_address     = mem_address_q;

    // Refill controller: miss detection, memory handshake, valid/flush bookkeeping
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            flush_pending_q <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_address_q   <= 28'h0;
            block_q         <= 128'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.flush) begin
                        valid_q <= '0;
                    end
                    if (bus.cpu_read && !hit) begin
                        state_q       <= MEM_READ;
                        mem_read_q    <= 1'b1;
                        mem_address_q <= {tag, index};
                    end
                end
                MEM_READ: begin
                    if (bus.flush) begin
                        flush_pending_q <= 1'b1;
                    end
                    if (!bus.mem_busywait) begin
                        block_q    <= bus.mem_readdata;
                        mem_read_q <= 1'b0;
                        state_q    <= UPDATE;
                    end
                end
                UPDATE: begin
                    // A flush seen during the fill (or in this very cycle) wipes the new line too
                    if (flush_pending_q || bus.flush) begin
                        valid_q         <= '0;
                        flush_pending_q <= 1'b0;
                    end else begin
                        valid_q[fill_index] <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    mem_read_q <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data arrays are plain storage; valid bits alone decide whether they mean anything
    always_ff @(posedge CLK) begin
        if (state_q == UPDATE) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= block_q;
        end
    end
endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb/tb_icache_direct_mapped.sv - randomized and directed self-checking bench for icache_direct_mapped
module tb_icache_direct_mapped;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    icache_direct_mapped_if bus ();

    icache_direct_mapped dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    bit          ref_valid [8];
    logic [24:0] ref_tag   [8];

    // Instruction memory contents: word address times 0x11, salted per block above block 0
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {2'b00, a[31:2]};
        return (w * 32'h11) ^ {a[15:4], 20'h0};
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic flush_idle();
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        model_clear();
    endtask

    // One fetch: acts as memory, measures stall, checks against the reference cache model.
    // flush_cyc: -1 none, 0 with the request in IDLE, >=1 during the refill.
    task automatic fetch(input logic [31:0] addr, input int lat, input int flush_cyc, input string name);
        logic [27:0] baddr;
        logic [2:0]  idx;
        logic [24:0] tg;
        logic [27:0] seen_addr;
        bit          exp_hit, seen_mem, done;
        int          exp_stall, stall, mem_cycles;
        baddr     = addr[31:4];
        idx       = addr[6:4];
        tg        = addr[31:7];
        exp_hit   = ref_valid[idx] && (ref_tag[idx] == tg);
        if (exp_hit)            exp_stall = 0;
        else if (flush_cyc >= 1) exp_stall = 2 * (2 + lat);
        else                    exp_stall = 2 + lat;
        seen_addr = 28'h0;
        seen_mem  = 1'b0;
        done      = 1'b0;
        stall     = 0;
        mem_cycles = 0;
        bus.cpu_read    = 1'b1;
        bus.cpu_address = addr;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            bus.flush = (k == flush_cyc);
            if (!bus.cpu_busywait) begin
                done = 1'b1;
                break;
            end
            stall++;
            if (bus.mem_read) begin
                if (!seen_mem) begin
                    seen_addr = bus.mem_address;
                    seen_mem  = 1'b1;
                end
                mem_cycles++;
                bus.mem_readdata = {mem_word({baddr, 4'hC}), mem_word({baddr, 4'h8}),
                                    mem_word({baddr, 4'h4}), mem_word({baddr, 4'h0})};
                bus.mem_busywait = (mem_cycles < lat);
            end else begin
                mem_cycles       = 0;
                bus.mem_busywait = 1'b1;
            end
        end
        check({name, "_done"}, {31'h0, done}, 32'h1);
        check({name, "_stall"}, stall, exp_stall);
        check({name, "_instr"}, bus.cpu_instruction, mem_word({addr[31:2], 2'b00}));
        if (!exp_hit) check({name, "_maddr"}, {4'h0, seen_addr}, {4'h0, baddr});
        @(posedge clk); #1;
        bus.cpu_read = 1'b0;
        bus.flush    = 1'b0;
        if (flush_cyc == 0 || (flush_cyc >= 1 && !exp_hit)) model_clear();
        if (!exp_hit) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] raddr;
        logic [24:0] tsel;
        bus.cpu_read     = 1'b0;
        bus.cpu_address  = 32'h0;
        bus.flush        = 1'b0;
        bus.mem_busywait = 1'b1;
        bus.mem_readdata = 128'h0;
        model_clear();
        rst_n = 1'b0;
        #4;
        check("rst_mem_read", {31'h0, bus.mem_read}, 32'h0);
        check("rst_busywait", {31'h0, bus.cpu_busywait}, 32'h0);
        check("rst_instr", bus.cpu_instruction, 32'h0);
        check("rst_maddr", {4'h0, bus.mem_address}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First fetch of address 0 stalls in the same cycle
        bus.cpu_read    = 1'b1;
        bus.cpu_address = 32'h0;
        #1;
        check("first_miss_comb", {31'h0, bus.cpu_busywait}, 32'h1);
        fetch(32'h0, 2, -1, "first");
        flush_idle();

        // Cold miss with a 3-cycle memory phase
        fetch(32'h4, 3, -1, "cold");
        fetch(32'h0, 1, -1, "hit0");
        fetch(32'h8, 1, -1, "hit8");
        fetch(32'hC, 1, -1, "hitC");

        // Conflict on index 0, then the evicted line misses again
        fetch(32'h80, 2, -1, "conflict");
        fetch(32'h4, 2, -1, "refetch");

        // Flush in IDLE, flush together with a request, flush during refill
        flush_idle();
        fetch(32'h4, 1, -1, "post_flush");
        fetch(32'h4, 1, 0, "flush_hit");
        fetch(32'h4, 2, 0, "flush_miss");
        fetch(32'h14, 2, 1, "flush_fill");

        // Randomized traffic over a few tags across all indices
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0:       tsel = 25'h0;
                1:       tsel = 25'h1;
                2:       tsel = 25'h2;
                default: tsel = 25'h1FFFFFF;
            endcase
            raddr = {tsel, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
            if ($urandom_range(0, 9) == 0) flush_idle();
            fetch(raddr, $urandom_range(1, 4), ($urandom_range(0, 7) == 0) ? 0 : -1, "rand");
        end

        // Reset in the middle of a refill
        flush_idle();
        fetch(32'h4, 1, -1, "pre_reset");
        bus.cpu_read     = 1'b1;
        bus.cpu_address  = 32'h40;
        bus.mem_busywait = 1'b1;
        @(posedge clk); #1;
        check("fill_mem_read", {31'h0, bus.mem_read}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_fill_mem_read", {31'h0, bus.mem_read}, 32'h0);
        check("rst_fill_maddr", {4'h0, bus.mem_address}, 32'h0);
        model_clear();
        #1;
        rst_n = 1'b1;
        bus.cpu_address = 32'h4;
        #1;
        check("rst_line_gone", {31'h0, bus.cpu_busywait}, 32'h1);
        bus.cpu_read = 1'b0;
        #1;
        check("rst_idle_busy", {31'h0, bus.cpu_busywait}, 32'h0);
        @(posedge clk); #1;
        fetch(32'h4, 2, -1, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
